// File: rtl/seg7_scan_driver.sv
// Two-digit common-anode 7-segment scan driver: captures two 4-bit values into
// shadow registers (unless frozen) and time-multiplexes them with blanking gaps.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count_up,
    input  logic [3:0] count_down,
    input  logic       freeze,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [1:0] an_n
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX       = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);

    localparam logic [1:0] S_DIG0_BLANK = 2'd0;
    localparam logic [1:0] S_DIG0_ON    = 2'd1;
    localparam logic [1:0] S_DIG1_BLANK = 2'd2;
    localparam logic [1:0] S_DIG1_ON    = 2'd3;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [1:0] AN_OFF  = 2'b11;

    generate
        if (REFRESH_DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_params
            $error("seg7_scan_driver: need REFRESH_DIV>=2 and 1<=BLANK_CYCLES<REFRESH_DIV");
        end
    endgenerate

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    shadow_up_q, shadow_up_d;
    logic [3:0]    shadow_dn_q, shadow_dn_d;
    logic          freeze_q, freeze_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [1:0]    an_q, an_d;

    always_comb begin
        cnt_d       = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        state_d     = state_q;
        shadow_up_d = freeze ? shadow_up_q : count_up;
        shadow_dn_d = freeze ? shadow_dn_q : count_down;
        freeze_d    = freeze;

        case (state_q)
            S_DIG0_BLANK: if (cnt_q == CNT_BLANK_END) state_d = S_DIG0_ON;
            S_DIG0_ON:    if (cnt_q == CNT_MAX)       state_d = S_DIG1_BLANK;
            S_DIG1_BLANK: if (cnt_q == CNT_BLANK_END) state_d = S_DIG1_ON;
            default:      if (cnt_q == CNT_MAX)       state_d = S_DIG0_BLANK;
        endcase
    end

    // Output register follows the current state, so an_n and seg_n switch
    // together and lag the state by one cycle.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        case (state_q)
            S_DIG0_ON: begin
                an_d  = 2'b10;
                seg_d = hex_to_seg(shadow_up_q);
                dp_d  = ~freeze_q;
            end
            S_DIG1_ON: begin
                an_d  = 2'b01;
                seg_d = hex_to_seg(shadow_dn_q);
                dp_d  = ~freeze_q;
            end
            default: begin
                an_d  = AN_OFF;
                seg_d = SEG_OFF;
                dp_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_DIG0_BLANK;
            cnt_q       <= '0;
            shadow_up_q <= 4'h0;
            shadow_dn_q <= 4'h0;
            freeze_q    <= 1'b0;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            an_q        <= AN_OFF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_up_q <= shadow_up_d;
            shadow_dn_q <= shadow_dn_d;
            freeze_q    <= freeze_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg_n = seg_q;
    assign dp_n  = dp_q;
    assign an_n  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (REFRESH_DIV=8, BLANK_CYCLES=2): decode table,
// directed multi-cycle sequences and random stress against a time-based model.
module tb_seg7_scan_driver;

    localparam int RD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count_up;
    logic [3:0] count_down;
    logic       freeze;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [1:0] an_n;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_up   (count_up),
        .count_down (count_down),
        .freeze     (freeze),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n)
    );

    typedef struct {
        logic [3:0] up;
        logic [3:0] dn;
        logic [6:0] s0;
        logic [6:0] s1;
    } vec_t;

    vec_t tbl [16];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: shadows plus elapsed edges since reset.
    logic [3:0] m_up, m_dn;
    logic       m_frz;
    int         m_pos;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [1:0] e_an;

    function automatic logic [6:0] ref_hex(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        int pos;
        @(posedge clk);
        if (rst) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 2'b11;
            m_up = 4'h0; m_dn = 4'h0; m_frz = 1'b0; m_pos = 0;
        end else begin
            pos = m_pos % (2 * RD);
            if ((pos % RD) >= BC) begin
                e_an  = (pos < RD) ? 2'b10 : 2'b01;
                e_seg = (pos < RD) ? ref_hex(m_up) : ref_hex(m_dn);
                e_dp  = ~m_frz;
            end else begin
                e_seg = 7'h7F; e_dp = 1'b1; e_an = 2'b11;
            end
            if (!freeze) begin
                m_up = count_up;
                m_dn = count_down;
            end
            m_frz = freeze;
            m_pos++;
        end
        #1;
        check("model", {seg_n, dp_n, an_n}, {e_seg, e_dp, e_an});
        check("an_both_on", {31'd0, an_n == 2'b00}, 32'd0);
    endtask

    task automatic wait_an(input logic [1:0] want);
        for (int k = 0; k < 40 && an_n !== want; k++) tick();
        check("wait_an", an_n, want);
    endtask

    initial begin
        logic [1:0] exp_an;
        logic       saw0, saw1;
        int         q;

        tbl[0]  = '{4'h0, 4'hF, 7'h40, 7'h0E};
        tbl[1]  = '{4'h1, 4'hE, 7'h79, 7'h06};
        tbl[2]  = '{4'h2, 4'hD, 7'h24, 7'h21};
        tbl[3]  = '{4'h3, 4'hC, 7'h30, 7'h46};
        tbl[4]  = '{4'h4, 4'hB, 7'h19, 7'h03};
        tbl[5]  = '{4'h5, 4'hA, 7'h12, 7'h08};
        tbl[6]  = '{4'h6, 4'h9, 7'h02, 7'h10};
        tbl[7]  = '{4'h7, 4'h8, 7'h78, 7'h00};
        tbl[8]  = '{4'h8, 4'h7, 7'h00, 7'h78};
        tbl[9]  = '{4'h9, 4'h6, 7'h10, 7'h02};
        tbl[10] = '{4'hA, 4'h5, 7'h08, 7'h12};
        tbl[11] = '{4'hB, 4'h4, 7'h03, 7'h19};
        tbl[12] = '{4'hC, 4'h3, 7'h46, 7'h30};
        tbl[13] = '{4'hD, 4'h2, 7'h21, 7'h24};
        tbl[14] = '{4'hE, 4'h1, 7'h06, 7'h79};
        tbl[15] = '{4'hF, 4'h0, 7'h0E, 7'h40};

        rst = 1'b1; freeze = 1'b0; count_up = 4'h0; count_down = 4'hF;
        m_up = 4'h0; m_dn = 4'h0; m_frz = 1'b0; m_pos = 0;

        // Reset and scan timing
        repeat (3) begin
            tick();
            check("rst_off", {seg_n, dp_n, an_n}, {7'h7F, 1'b1, 2'b11});
        end
        rst = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k < 3) exp_an = 2'b11;
            else begin
                q = (k - 3) % 16;
                exp_an = (q < 6) ? 2'b10 : (q < 8) ? 2'b11 : (q < 14) ? 2'b01 : 2'b11;
            end
            check("scan_an", an_n, exp_an);
            if (k >= 3 && an_n == 2'b10) check("dec_0", seg_n, 7'h40);
            if (k >= 3 && an_n == 2'b01) check("dec_F", seg_n, 7'h0E);
        end

        // Decode sweep
        for (int i = 0; i < 16; i++) begin
            count_up = tbl[i].up; count_down = tbl[i].dn; freeze = 1'b0;
            saw0 = 1'b0; saw1 = 1'b0;
            repeat (2) tick();
            for (int j = 0; j < 16; j++) begin
                tick();
                if (an_n == 2'b10) begin check("dec_dig0", {seg_n, dp_n}, {tbl[i].s0, 1'b1}); saw0 = 1'b1; end
                if (an_n == 2'b01) begin check("dec_dig1", {seg_n, dp_n}, {tbl[i].s1, 1'b1}); saw1 = 1'b1; end
            end
            check("dec_seen", {saw0, saw1}, 2'b11);
        end

        // Freeze holds captured value, dp lit while frozen
        count_up = 4'h3;
        repeat (2) tick();
        freeze = 1'b1;
        repeat (2) tick();
        count_up = 4'h9;
        saw0 = 1'b0;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (an_n == 2'b10) begin check("frz_hold", {seg_n, dp_n}, {7'h30, 1'b0}); saw0 = 1'b1; end
        end
        check("frz_seen", saw0, 1'b1);
        wait_an(2'b10);
        freeze = 1'b0;
        tick();
        tick();
        check("unfrz_2edges", {seg_n, dp_n, an_n}, {7'h10, 1'b1, 2'b10});

        // Mid-slot update
        rst = 1'b1; tick(); rst = 1'b0;
        count_up = 4'h1; count_down = 4'h0;
        wait_an(2'b10);
        tick();
        check("mid_before", {seg_n, an_n}, {7'h79, 2'b10});
        count_up = 4'h8;
        tick();
        check("mid_edge1", {seg_n, an_n}, {7'h79, 2'b10});
        tick();
        check("mid_edge2", {seg_n, an_n}, {7'h00, 2'b10});

        // Reset during DIG1_ON; freeze keeps shadows at their reset value
        wait_an(2'b01);
        rst = 1'b1; count_up = 4'h5; count_down = 4'h7; freeze = 1'b1;
        tick();
        check("rst_mid_off", {seg_n, dp_n, an_n}, {7'h7F, 1'b1, 2'b11});
        rst = 1'b0;
        tick();
        check("rst_rel1", an_n, 2'b11);
        tick();
        check("rst_rel2", an_n, 2'b11);
        tick();
        check("rst_dig0_zero", {seg_n, dp_n, an_n}, {7'h40, 1'b0, 2'b10});

        // Random stress
        for (int k = 0; k < 10000; k++) begin
            rst        = ($urandom_range(0, 63) == 0);
            freeze     = ($urandom_range(0, 3) == 0);
            count_up   = 4'($urandom_range(0, 15));
            count_down = 4'($urandom_range(0, 15));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
